btn_event_decoder: RTL and testbench
====================================

BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, clock frequency in Hz; must be a multiple of 1000 and at least 1000.
REQ-002 SHALL have parameter LONG_PRESS_MS, default 1000, hold time in ms at which a press becomes a long press; must be greater than 0.
REQ-003 SHALL have parameter DOUBLE_GAP_MS, default 300, maximum release gap in ms between two presses for a double press; must be greater than 0.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_clean_i  input  1  debounced button, active-low (0 = pressed), synchronous to clk.
REQ-007 SHALL have port short_o  output  1  single-cycle pulse on a short press.
REQ-008 SHALL have port long_o  output  1  single-cycle pulse on a long press.
REQ-009 SHALL have port double_o  output  1  single-cycle pulse on a double press.

Function
REQ-010 SHALL fail elaboration on any illegal parameter value from REQ-001 to REQ-003.
REQ-011 SHALL define N_MS = CLK_FREQ/1000, L = LONG_PRESS_MS*N_MS and G = DOUBLE_GAP_MS*N_MS.
REQ-012 SHALL detect press and release edges from btn_clean_i against a registered previous sample (press = prev 1, current 0; release = prev 0, current 1).
REQ-013 SHALL implement the FSM states IDLE, PRESS1, LONG_HOLD, WAIT_GAP and PRESS2.
REQ-014 SHALL clear the ms prescaler and the ms counter on every state transition, so each elapsed time is exact in cycles.
REQ-015 SHALL transition IDLE to PRESS1 on a press edge.
REQ-016 SHALL, in PRESS1, pulse long_o and go to LONG_HOLD in the cycle where L cycles have elapsed since entry.
REQ-017 SHALL, in PRESS1, go to WAIT_GAP on a release edge that occurs before L cycles have elapsed.
REQ-018 SHALL, in PRESS1, give the long threshold priority when a release edge and the long threshold coincide.
REQ-019 SHALL, in LONG_HOLD, return to IDLE on a release edge and emit no event.
REQ-020 SHALL, in WAIT_GAP, go to PRESS2 on a press edge that occurs before G cycles have elapsed.
REQ-021 SHALL, in WAIT_GAP, pulse short_o and go to IDLE in the cycle where G cycles have elapsed.
REQ-022 SHALL, in WAIT_GAP, pulse short_o and go directly to PRESS1 when a press edge coincides with the G-cycle timeout.
REQ-023 SHALL, in PRESS2, pulse double_o and go to IDLE on a release edge; PRESS2 has no long detection.
REQ-024 SHALL drive short_o, long_o and double_o from registers, asserted for exactly one cycle and mutually exclusive.
REQ-025 SHALL size the ms counter as $clog2(max(LONG_PRESS_MS, DOUBLE_GAP_MS)+1) bits, with no wrap-around possible.

Reset
REQ-026 SHALL, on rst_n low, immediately force the state to IDLE, clear the prescaler and counter, and drive short_o, long_o and double_o to 0.
REQ-027 SHALL reset the previous-sample register to 1 (released).
REQ-028 SHALL therefore treat a button already held at reset release as a fresh press.
REQ-029 SHALL discard any partially detected event on reset and never emit a pulse for it.

Structure
REQ-030 SHALL place the state enum typedef and the default timing constants in the shared package btn_event_pkg.
REQ-031 SHALL implement the ms prescaler as sub-module ms_tick_gen (parameter N_MS; inputs clk, rst_n, clr_i; output tick_o, asserted every N_MS cycles after clr_i).

Verification (CLK_FREQ=10_000, LONG_PRESS_MS=10, DOUBLE_GAP_MS=3, giving L=100 and G=30)
REQ-032 SHALL verify: press 40 cycles then release -> one short_o pulse 30 cycles after release detection, no other pulses.
REQ-033 SHALL verify: hold 150 cycles -> long_o pulse exactly 100 cycles after press detection, nothing on release.
REQ-034 SHALL verify: press 20, release 10, press 20, release -> one double_o pulse on the second release, no short_o.
REQ-035 SHALL verify: release exactly at cycle 100 of PRESS1 -> long_o only, FSM back to IDLE next cycle, no short_o.
REQ-036 SHALL verify: rst_n low for 3 cycles mid-WAIT_GAP -> all outputs 0, no short_o; the next press is decoded as a first press.
REQ-037 SHALL verify: second press edge exactly at G-cycle timeout -> short_o pulse and FSM in PRESS1; holding 100 cycles then yields long_o.

Source files
------------

// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared state encoding, default timing constants and helpers for the button decoder
package btn_event_pkg;
  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HOLD, WAIT_GAP, PRESS2} state_e;
  localparam int DEF_CLK_FREQ      = 50_000_000;
  localparam int DEF_LONG_PRESS_MS = 1000;
  localparam int DEF_DOUBLE_GAP_MS = 300;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: pulses tick_o once every N_MS cycles, restarting the period on clr_i
module ms_tick_gen #(
  parameter int N_MS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int PW = (N_MS > 1) ? $clog2(N_MS) : 1;
  logic [PW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == PW'(N_MS - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies a debounced active-low button into short, long and double press pulses
module btn_event_decoder
  import btn_event_pkg::*;
#(
  parameter int CLK_FREQ      = DEF_CLK_FREQ,
  parameter int LONG_PRESS_MS = DEF_LONG_PRESS_MS,
  parameter int DOUBLE_GAP_MS = DEF_DOUBLE_GAP_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_clean_i,
  output logic short_o,
  output logic long_o,
  output logic double_o
);
  localparam int N_MS   = CLK_FREQ / 1000;
  localparam int MAX_MS = max_int(LONG_PRESS_MS, DOUBLE_GAP_MS);
  localparam int CW     = $clog2(MAX_MS + 1);
  if (CLK_FREQ < 1000 || CLK_FREQ % 1000 != 0) begin : g_bad_clk
    $error("btn_event_decoder: CLK_FREQ must be a multiple of 1000 and at least 1000");
  end
  if (LONG_PRESS_MS <= 0) begin : g_bad_long
    $error("btn_event_decoder: LONG_PRESS_MS must be greater than 0");
  end
  if (DOUBLE_GAP_MS <= 0) begin : g_bad_gap
    $error("btn_event_decoder: DOUBLE_GAP_MS must be greater than 0");
  end
  state_e state_q, state_d;
  logic [CW-1:0] ms_cnt_q, ms_cnt_d;
  logic prev_q, short_q, short_d, long_q, long_d, double_q, double_d;
  logic press, release_e, tick, clr, long_hit, gap_hit;
  assign press     = prev_q & ~btn_clean_i;
  assign release_e = ~prev_q & btn_clean_i;
  assign clr       = state_d != state_q;
  // Hits fire in the last cycle of the window so the transition lands exactly L/G cycles after entry.
  assign long_hit  = tick && ms_cnt_q == CW'(LONG_PRESS_MS - 1);
  assign gap_hit   = tick && ms_cnt_q == CW'(DOUBLE_GAP_MS - 1);
  ms_tick_gen #(.N_MS(N_MS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .tick_o(tick)
  );
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE:      state_d = press ? PRESS1 : IDLE;
      PRESS1: begin
        long_d  = long_hit;
        state_d = long_hit ? LONG_HOLD : release_e ? WAIT_GAP : PRESS1;
      end
      // Level check so a release coinciding with the long threshold still returns to IDLE.
      LONG_HOLD: state_d = btn_clean_i ? IDLE : LONG_HOLD;
      WAIT_GAP: begin
        short_d = gap_hit;
        state_d = gap_hit ? (press ? PRESS1 : IDLE) : press ? PRESS2 : WAIT_GAP;
      end
      PRESS2: begin
        double_d = release_e;
        state_d  = release_e ? IDLE : PRESS2;
      end
      default:   state_d = IDLE;
    endcase
  end
  always_comb
    ms_cnt_d = clr ? '0 : (tick && ms_cnt_q != CW'(MAX_MS)) ? ms_cnt_q + 1'b1 : ms_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      ms_cnt_q <= '0;
      prev_q   <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_cnt_q <= ms_cnt_d;
      prev_q   <= btn_clean_i;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  assign short_o  = short_q;
  assign long_o   = long_q;
  assign double_o = double_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed stimulus with a queue-based scoreboard for btn_event_decoder
module tb_btn_event_decoder;
  localparam logic [2:0] EV_S = 3'b001, EV_L = 3'b010, EV_D = 3'b100;
  typedef struct {logic [2:0] kind; int cyc;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b1;
  logic short_o, long_o, double_o;
  int cyc = 0, n_checks = 0, n_pass = 0, c0;
  string tname = "reset";
  exp_t q[$];
  exp_t e;

  btn_event_decoder #(.CLK_FREQ(10_000), .LONG_PRESS_MS(10), .DOUBLE_GAP_MS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_clean_i(btn),
    .short_o    (short_o),
    .long_o     (long_o),
    .double_o   (double_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic expect_ev(input logic [2:0] k, input int c);
    q.push_back('{k, c});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (short_o || long_o || double_o) begin
      if (q.size() == 0) check({tname, ":unexpected_pulse"}, int'({double_o, long_o, short_o}), 0);
      else begin
        e = q.pop_front();
        check({tname, ":kind"}, int'({double_o, long_o, short_o}), int'(e.kind));
        check({tname, ":cycle"}, cyc, e.cyc);
      end
    end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    step(3);
    check("reset:short", int'(short_o), 0);
    check("reset:long", int'(long_o), 0);
    check("reset:double", int'(double_o), 0);
    rst_n = 1'b1;
    step(5);
    tname = "short";
    btn = 1'b0; step(40); btn = 1'b1;
    expect_ev(EV_S, cyc + 31);
    step(60);
    tname = "long";
    btn = 1'b0; c0 = cyc;
    expect_ev(EV_L, c0 + 101);
    step(150); btn = 1'b1; step(40);
    tname = "double";
    btn = 1'b0; step(20); btn = 1'b1; step(10); btn = 1'b0; step(20); btn = 1'b1;
    expect_ev(EV_D, cyc + 1);
    step(60);
    tname = "hold99";
    btn = 1'b0; step(99); btn = 1'b1;
    expect_ev(EV_S, cyc + 31);
    step(60);
    tname = "release_at_long";
    btn = 1'b0; c0 = cyc;
    expect_ev(EV_L, c0 + 101);
    step(100); btn = 1'b1; step(10);
    btn = 1'b0; step(10); btn = 1'b1;
    expect_ev(EV_S, cyc + 31);
    step(60);
    tname = "reset_in_gap";
    btn = 1'b0; step(20); btn = 1'b1; step(10);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_in_gap:outputs", int'({double_o, long_o, short_o}), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(40);
    btn = 1'b0; step(20); btn = 1'b1;
    expect_ev(EV_S, cyc + 31);
    step(60);
    tname = "press_at_gap_timeout";
    btn = 1'b0; step(20); btn = 1'b1; step(30); btn = 1'b0;
    expect_ev(EV_S, cyc + 1);
    expect_ev(EV_L, cyc + 101);
    step(150); btn = 1'b1; step(40);
    tname = "held_through_reset";
    btn = 1'b0; step(2);
    rst_n = 1'b0; step(3); rst_n = 1'b1;
    expect_ev(EV_L, cyc + 101);
    step(150); btn = 1'b1; step(40);
    tname = "end";
    step(20);
    check("end:queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
